id_stage: RTL

//  Instruction-decode stage of the 16-bit pipeline; feeds the ID/EX pipeline register.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/reg_file.sv | 47 ++++
 rtl/id_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction fields,
// ALU commands, ID stage FSM state and decoded control bundle.
package pipe_pkg;

  localparam int INST_W = 16;

  localparam int OP_LO  = 12;
  localparam int RD_LO  = 9;
  localparam int RS_LO  = 6;
  localparam int RT_LO  = 3;
  localparam int FN_LO  = 0;
  localparam int IMM_W  = 6;

  localparam logic [3:0] OP_RALU = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } id_state_e;

  typedef struct packed {
    logic       wr_en;
    logic       src2_imm;
    logic       mem_store;
    logic       wb_mem;
    logic [2:0] alu_cmd;
    logic       use_rs;
    logic       use_rt;
    logic       use_rd;
  } id_ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Register file: 2**REG_AW x DATA_W, two combinational read ports
// with write bypass, one write port; register 0 is hard-wired zero.
module reg_file
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && waddr != '0) begin
      mem_q[waddr] <= wdata;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [REG_AW-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = mem_q[a];
    if (a == '0) v = '0;
    else if (we && waddr == a) v = wdata;
    return v;
  endfunction

  assign rdata1 = rd_port(raddr1);
  assign rdata2 = rd_port(raddr2);

endmodule

// File: rtl/id_stage.sv
// Decode stage: register file, instruction decode, load-use
// hazard detection with a one-bubble RUN/STALL FSM and stall counter.
module id_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       inst,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_wr_en,
  input  logic              ex_wb_mem_sel,
  input  logic [REG_AW-1:0] ex_write_addr,
  output logic [15:0]       inst_out,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  output logic [DATA_W-1:0] imm_data,
  output logic              wr_en,
  output logic              alu_src2_sel_rf_imm,
  output logic              mem_store,
  output logic              wb_mem_select,
  output logic [2:0]        alu_cmd,
  output logic [REG_AW-1:0] write_addr,
  output logic              ctrl_regs_sel,
  output logic              pc_hold,
  output logic [CNT_W-1:0]  stall_count
);

  logic [3:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [2:0]        fn;
  logic [IMM_W-1:0]  imm6;

  assign op   = inst[OP_LO +: 4];
  assign rd   = inst[RD_LO +: REG_AW];
  assign rs   = inst[RS_LO +: REG_AW];
  assign rt   = inst[RT_LO +: REG_AW];
  assign fn   = inst[FN_LO +: 3];
  assign imm6 = inst[0 +: IMM_W];

  id_ctrl_t ctl;

  always_comb begin
    ctl = '0;
    unique case (1'b1)
      op == OP_RALU: begin
        ctl.wr_en   = 1'b1;
        ctl.alu_cmd = fn;
        ctl.use_rs  = 1'b1;
        ctl.use_rt  = 1'b1;
      end
      op == OP_ADDI: begin
        ctl.wr_en    = 1'b1;
        ctl.src2_imm = 1'b1;
        ctl.alu_cmd  = ALU_ADD;
        ctl.use_rs   = 1'b1;
      end
      op == OP_LW: begin
        ctl.wr_en    = 1'b1;
        ctl.src2_imm = 1'b1;
        ctl.wb_mem   = 1'b1;
        ctl.alu_cmd  = ALU_ADD;
        ctl.use_rs   = 1'b1;
      end
      op == OP_SW: begin
        ctl.mem_store = 1'b1;
        ctl.src2_imm  = 1'b1;
        ctl.alu_cmd   = ALU_ADD;
        ctl.use_rs    = 1'b1;
        ctl.use_rd    = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Stores read the data register (rd) through port 2.
  logic [REG_AW-1:0] raddr2;
  assign raddr2 = ctl.use_rd ? rd : rt;

  reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs),
    .raddr2 (raddr2),
    .rdata1 (read1),
    .rdata2 (read2)
  );

  assign inst_out            = inst;
  assign imm_data            = {{(DATA_W-IMM_W){imm6[IMM_W-1]}}, imm6};
  assign wr_en               = ctl.wr_en;
  assign alu_src2_sel_rf_imm = ctl.src2_imm;
  assign mem_store           = ctl.mem_store;
  assign wb_mem_select       = ctl.wb_mem;
  assign alu_cmd             = ctl.alu_cmd;
  assign write_addr          = ctl.wr_en ? rd : '0;

  logic ld_in_ex;
  logic hazard;

  assign ld_in_ex = ex_wr_en & ex_wb_mem_sel
                  & (ex_write_addr != '0);

  assign hazard = ld_in_ex & (
      (ctl.use_rs & (ex_write_addr == rs))
    | (ctl.use_rt & (ex_write_addr == rt))
    | (ctl.use_rd & (ex_write_addr == rd)));

  id_state_e        state_q;
  logic [CNT_W-1:0] stall_count_q;
  logic             stall_fire;

  assign stall_fire = (state_q == ST_RUN) & hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            state_q <= ST_STALL;
            if (stall_count_q != '1)
              stall_count_q <= stall_count_q + 1'b1;
          end
        end
        ST_STALL: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Gated by rst so the stall request drops as soon as reset asserts.
  assign pc_hold       = rst & stall_fire;
  assign ctrl_regs_sel = rst & stall_fire;
  assign stall_count   = stall_count_q;

endmodule
